tinynpu_seq_ctrl: RTL and testbench
===================================

Name: tinynpu_seq_ctrl

Overview:
Multi-layer sequencing controller for the TinyNPU systolic datapath. It generalises the single-pass controller in four ways: parametrised MAC pipeline latency, a configurable layer count with output-to-input writeback between layers, a fully implemented output-drain state with a valid/ready handshake, and a start/busy/done host interface. It sits between the host load interface and the x/w FIFOs, MAC array and output mux, and drives only control signals.

Parameters:
SIZE, 4, array dimension (number of w FIFOs and output lanes); power of 2, >=2
MAC_LAT, 3, cycles from the last streamed operand to a valid MAC result; >=1
MAX_LAYERS, 8, maximum supported layer count; LW = $clog2(MAX_LAYERS)+1

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
start  in  1  begin a job; sampled only in IDLE
cfg_layers  in  LW  layer count for the job; latched on start
d2c_x_load_val  in  1  host x word valid
d2c_w_load_val  in  1  host w word valid
d2c_w_load_sel  in  $clog2(SIZE)  target w FIFO
d2c_mac_go  in  1  host signals loading complete
d2c_x_fifo_empty  in  1  x FIFO empty
d2c_w_fifo_empty  in  SIZE  per-lane w FIFO empty
out_rdy  in  1  downstream accepts output word
c2d_x_sel  out  1  x FIFO source: 0 = host, 1 = MAC writeback
c2d_x_fifo_wen  out  1  x FIFO write
c2d_w_fifo_wen  out  SIZE  one-hot w FIFO write
c2d_istream_val  out  1  operands valid into array
c2d_x_fifo_ren  out  1  x FIFO read
c2d_w_fifo_ren  out  1  all w FIFOs read
c2d_ostream_req  out  1  capture MAC results
c2d_ostream_sel  out  $clog2(SIZE)  output lane select
c2d_mac_rst  out  1  clear accumulators
out_val  out  1  output word valid
busy  out  1  high in any state except IDLE
done  out  1  single-cycle job-complete pulse
layer_idx  out  LW  current layer, 0-based
trace_state  out  4  state encoding

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; all counters, layer_idx and latched cfg cleared; every output 0. Reset mid-job aborts immediately; no done pulse.
- State encoding: IDLE=0, LOAD=1, MAC=2, DRAIN=3, WB=4, OUT=5, DONE=6. State register uses one always-enabled update.
- empty = d2c_x_fifo_empty AND all d2c_w_fifo_empty bits.
- IDLE: on start -> LOAD. Latch layers = (cfg_layers==0 ? 1 : min(cfg_layers, MAX_LAYERS)); layer_idx=0.
- LOAD: c2d_w_fifo_wen[i] = d2c_w_load_val & (d2c_w_load_sel==i). c2d_x_fifo_wen = d2c_x_load_val only when layer_idx==0, otherwise 0. c2d_x_sel=0. On d2c_mac_go -> MAC.
- MAC: c2d_istream_val = c2d_x_fifo_ren = c2d_w_fifo_ren = ~empty. When empty -> DRAIN; if already empty on entry, transition after one cycle.
- DRAIN: latency counter starts at 0 on entry and increments each cycle. In the cycle the counter equals MAC_LAT-1, c2d_ostream_req=1 for exactly one cycle. Next state: WB if layer_idx < layers-1, else OUT. Counter clears on exit.
- WB: lane counter runs 0..SIZE-1, one per cycle. c2d_ostream_sel = lane; c2d_x_sel=1; c2d_x_fifo_wen=1. On the cycle after the last lane: c2d_mac_rst=1 for one cycle, layer_idx++, -> LOAD.
- OUT: out_val=1; c2d_ostream_sel = lane. Lane advances only on out_val & out_rdy; out_val and lane hold while out_rdy=0. Handshake on lane SIZE-1 -> DONE.
- DONE: done=1 and c2d_mac_rst=1 for one cycle, then -> IDLE. layer_idx holds its final value until the next start.
- Host load strobes outside LOAD are ignored. start outside IDLE is ignored. Counters are sized to avoid wrap; lane counter resets to 0 on every WB/OUT entry.
- trace_state = zero-extended state.

Test Plan:
- SIZE=4, MAC_LAT=3, cfg_layers=1; load 4 x + 4 w words, mac_go, FIFOs drain in 4 cycles -> ostream_req exactly 3 cycles after DRAIN entry; OUT lanes 0,1,2,3 with out_rdy=1; done pulse 1 cycle; busy falls.
- cfg_layers=3 -> two WB passes, each 4 cycles with x_sel=1, x_fifo_wen=1, sel 0..3; mac_rst after each; layer_idx 0->1->2; host x strobes in LOAD at layer 1 produce no x_fifo_wen.
- Backpressure in OUT: out_rdy pattern 1,0,0,1,1,0,1 -> out_val stays high; sel sequence 0,1,1,1,2,3,3; DONE follows the 4th handshake.
- Boundaries: cfg_layers=0 behaves as 1; d2c_mac_go with FIFOs already empty -> MAC lasts 1 cycle; MAC_LAT=1 -> ostream_req in the first DRAIN cycle; d2c_w_load_sel=2 with w_load_val -> only c2d_w_fifo_wen[2].
- Assert rst=0 during WB at layer 1 -> all outputs 0 asynchronously, state=IDLE, no done pulse; a new start runs a clean 1-layer job.

Source files
------------

// File: rtl/tinynpu_seq_ctrl.sv
// TinyNPU multi-layer sequencer: LOAD -> MAC -> DRAIN -> (WB -> LOAD)* -> OUT -> DONE.
// Control outputs decode directly from state; OUT holds out_val and its lane while out_rdy is low.
module tinynpu_seq_ctrl #(
  parameter int SIZE       = 4,
  parameter int MAC_LAT    = 3,
  parameter int MAX_LAYERS = 8,
  localparam int LW = $clog2(MAX_LAYERS) + 1,
  localparam int SW = $clog2(SIZE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [LW-1:0] cfg_layers,
  input  logic          d2c_x_load_val,
  input  logic          d2c_w_load_val,
  input  logic [SW-1:0] d2c_w_load_sel,
  input  logic          d2c_mac_go,
  input  logic          d2c_x_fifo_empty,
  input  logic [SIZE-1:0] d2c_w_fifo_empty,
  input  logic          out_rdy,
  output logic          c2d_x_sel,
  output logic          c2d_x_fifo_wen,
  output logic [SIZE-1:0] c2d_w_fifo_wen,
  output logic          c2d_istream_val,
  output logic          c2d_x_fifo_ren,
  output logic          c2d_w_fifo_ren,
  output logic          c2d_ostream_req,
  output logic [SW-1:0] c2d_ostream_sel,
  output logic          c2d_mac_rst,
  output logic          out_val,
  output logic          busy,
  output logic          done,
  output logic [LW-1:0] layer_idx,
  output logic [3:0]    trace_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    MAC   = 3'd2,
    DRAIN = 3'd3,
    WB    = 3'd4,
    OUT   = 3'd5,
    DONE  = 3'd6
  } state_t;

  localparam int CW = $clog2(MAC_LAT) + 1;
  localparam logic [CW-1:0] LAT_LAST  = CW'(MAC_LAT - 1);
  localparam logic [SW:0]   LANE_LAST = (SW+1)'(SIZE - 1);
  localparam logic [SW:0]   LANE_END  = (SW+1)'(SIZE);
  localparam logic [LW-1:0] MAX_L     = LW'(MAX_LAYERS);

  state_t        state, state_nxt;
  logic [CW-1:0] lat_cnt;
  logic [SW:0]   lane;
  logic [LW-1:0] layers;
  logic [LW-1:0] cfg_clamped;
  logic          empty;
  logic          more_layers;

  assign empty       = d2c_x_fifo_empty & (&d2c_w_fifo_empty);
  assign cfg_clamped = (cfg_layers == '0)   ? LW'(1) :
                       (cfg_layers > MAX_L) ? MAX_L  : cfg_layers;
  assign more_layers = layer_idx < (layers - LW'(1));
  assign busy        = (state != IDLE);
  assign trace_state = {1'b0, state};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_cnt   <= '0;
      lane      <= '0;
      layers    <= '0;
      layer_idx <= '0;
    end else begin
      lat_cnt <= (state == DRAIN && state_nxt == DRAIN) ? lat_cnt + 1'b1 : '0;
      // Lane restarts from 0 on every state change so each WB/OUT pass begins at lane 0.
      if (state_nxt != state)
        lane <= '0;
      else if (state == WB || (state == OUT && out_rdy))
        lane <= lane + 1'b1;
      if (state == IDLE && start) begin
        layers    <= cfg_clamped;
        layer_idx <= '0;
      end else if (state == WB && lane == LANE_END) begin
        layer_idx <= layer_idx + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt       = state;
    c2d_x_sel       = 1'b0;
    c2d_x_fifo_wen  = 1'b0;
    c2d_w_fifo_wen  = '0;
    c2d_istream_val = 1'b0;
    c2d_x_fifo_ren  = 1'b0;
    c2d_w_fifo_ren  = 1'b0;
    c2d_ostream_req = 1'b0;
    c2d_ostream_sel = '0;
    c2d_mac_rst     = 1'b0;
    out_val         = 1'b0;
    done            = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = LOAD;
      LOAD: begin
        for (int i = 0; i < SIZE; i++)
          c2d_w_fifo_wen[i] = d2c_w_load_val && (d2c_w_load_sel == SW'(i));
        // Layers after the first take x from the writeback path, not the host.
        c2d_x_fifo_wen = d2c_x_load_val && (layer_idx == '0);
        if (d2c_mac_go) state_nxt = MAC;
      end
      MAC: begin
        c2d_istream_val = ~empty;
        c2d_x_fifo_ren  = ~empty;
        c2d_w_fifo_ren  = ~empty;
        if (empty) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (lat_cnt == LAT_LAST) begin
          c2d_ostream_req = 1'b1;
          state_nxt       = more_layers ? WB : OUT;
        end
      end
      WB: begin
        c2d_x_sel = 1'b1;
        if (lane == LANE_END) begin
          c2d_mac_rst = 1'b1;
          state_nxt   = LOAD;
        end else begin
          c2d_x_fifo_wen  = 1'b1;
          c2d_ostream_sel = lane[SW-1:0];
        end
      end
      OUT: begin
        out_val         = 1'b1;
        c2d_ostream_sel = lane[SW-1:0];
        if (out_rdy && lane == LANE_LAST) state_nxt = DONE;
      end
      DONE: begin
        done        = 1'b1;
        c2d_mac_rst = 1'b1;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_tinynpu_seq_ctrl.sv
// Directed bench for tinynpu_seq_ctrl: main instance MAC_LAT=3, second instance MAC_LAT=1.
module tb_tinynpu_seq_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, rst1, start, xl, wl, go, xe, rdy;
  logic [3:0] cfg, we;
  logic [1:0] wsel;

  logic       x_sel0, x_wen0, strm0, x_ren0, w_ren0, req0, mrst0, ov0, busy0, done0;
  logic [3:0] w_wen0, li0, ts0;
  logic [1:0] sel0;
  logic       x_sel1, x_wen1, strm1, x_ren1, w_ren1, req1, mrst1, ov1, busy1, done1;
  logic [3:0] w_wen1, li1, ts1;
  logic [1:0] sel1;

  tinynpu_seq_ctrl #(.SIZE(4), .MAC_LAT(3), .MAX_LAYERS(8)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_layers(cfg),
    .d2c_x_load_val(xl), .d2c_w_load_val(wl), .d2c_w_load_sel(wsel), .d2c_mac_go(go),
    .d2c_x_fifo_empty(xe), .d2c_w_fifo_empty(we), .out_rdy(rdy),
    .c2d_x_sel(x_sel0), .c2d_x_fifo_wen(x_wen0), .c2d_w_fifo_wen(w_wen0),
    .c2d_istream_val(strm0), .c2d_x_fifo_ren(x_ren0), .c2d_w_fifo_ren(w_ren0),
    .c2d_ostream_req(req0), .c2d_ostream_sel(sel0), .c2d_mac_rst(mrst0),
    .out_val(ov0), .busy(busy0), .done(done0), .layer_idx(li0), .trace_state(ts0)
  );

  tinynpu_seq_ctrl #(.SIZE(4), .MAC_LAT(1), .MAX_LAYERS(8)) dut_lat1 (
    .clk(clk), .rst(rst1), .start(start), .cfg_layers(cfg),
    .d2c_x_load_val(xl), .d2c_w_load_val(wl), .d2c_w_load_sel(wsel), .d2c_mac_go(go),
    .d2c_x_fifo_empty(xe), .d2c_w_fifo_empty(we), .out_rdy(rdy),
    .c2d_x_sel(x_sel1), .c2d_x_fifo_wen(x_wen1), .c2d_w_fifo_wen(w_wen1),
    .c2d_istream_val(strm1), .c2d_x_fifo_ren(x_ren1), .c2d_w_fifo_ren(w_ren1),
    .c2d_ostream_req(req1), .c2d_ostream_sel(sel1), .c2d_mac_rst(mrst1),
    .out_val(ov1), .busy(busy1), .done(done1), .layer_idx(li1), .trace_state(ts1)
  );

  wire [22:0] obs0 = {ts0, li0, busy0, done0, ov0, req0, sel0, mrst0, strm0, x_ren0, w_ren0,
                      x_sel0, x_wen0, w_wen0};
  wire [22:0] obs1 = {ts1, li1, busy1, done1, ov1, req1, sel1, mrst1, strm1, x_ren1, w_ren1,
                      x_sel1, x_wen1, w_wen1};

  int passed = 0;
  int total  = 0;

  // Expected output vector in the same bit order as obs0/obs1; busy is high outside IDLE.
  function automatic logic [22:0] ev(input int st, input int li, input logic dn, input logic ov,
                                     input logic rq, input int sel, input logic mrst,
                                     input logic strm, input logic xsel, input logic xwen,
                                     input logic [3:0] wwen);
    logic [3:0] s4, l4;
    logic [1:0] sl;
    s4 = st[3:0];
    l4 = li[3:0];
    sl = sel[1:0];
    return {s4, l4, (st != 0), dn, ov, rq, sl, mrst, strm, strm, strm, xsel, xwen, wwen};
  endfunction

  task automatic drv(input logic s, input logic [3:0] cl, input logic x, input logic w,
                     input logic [1:0] ws, input logic g, input logic xemp,
                     input logic [3:0] wemp, input logic r);
    start = s; cfg = cl; xl = x; wl = w; wsel = ws; go = g; xe = xemp; we = wemp; rdy = r;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [22:0] e;
    rst = 1'b0; rst1 = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 1, 4'hF, 0);
    #3;
    e = '0;
    total++; if (obs0 !== e) $display("FAIL reset_main: got %h want %h", obs0, e); else passed++;
    total++; if (obs1 !== e) $display("FAIL reset_lat1: got %h want %h", obs1, e); else passed++;
    @(negedge clk); rst = 1'b1; rst1 = 1'b1;
    tick();
  endtask

  task automatic test_single_layer;
    logic [22:0] e;
    logic [3:0] xes [5] = '{4'h0, 4'h1, 4'h0, 4'h1, 4'h1};
    logic [3:0] wes [5] = '{4'h0, 4'hE, 4'hF, 4'h7, 4'hF};
    drv(1, 1, 0, 0, 0, 0, 1, 4'hF, 0); #1;
    e = ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0);
    total++; if (obs0 !== e) $display("FAIL single_idle: got %h want %h", obs0, e); else passed++;
    tick();
    for (int i = 0; i < 4; i++) begin
      drv(0, 1, 1, 1, 2'(i), 0, 0, 4'h0, 0); #1;
      e = ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'(1 << i));
      total++; if (obs0 !== e) $display("FAIL single_load[%0d]: got %h want %h", i, obs0, e); else passed++;
      tick();
    end
    drv(0, 1, 0, 0, 0, 1, 0, 4'h0, 0); #1;
    e = ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0);
    total++; if (obs0 !== e) $display("FAIL single_go: got %h want %h", obs0, e); else passed++;
    tick();
    for (int i = 0; i < 5; i++) begin
      drv(0, 1, 0, 0, 0, 0, xes[i][0], wes[i], 0); #1;
      e = ev(2, 0, 0, 0, 0, 0, 0, (i < 4), 0, 0, 4'h0);
      total++; if (obs0 !== e) $display("FAIL single_mac[%0d]: got %h want %h", i, obs0, e); else passed++;
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      #1;
      e = ev(3, 0, 0, 0, (k == 2), 0, 0, 0, 0, 0, 4'h0);
      total++; if (obs0 !== e) $display("FAIL single_drain[%0d]: got %h want %h", k, obs0, e); else passed++;
      e = (k == 0) ? ev(3, 0, 0, 0, 1, 0, 0, 0, 0, 0, 4'h0) : ev(5, 0, 0, 1, 0, 0, 0, 0, 0, 0, 4'h0);
      total++; if (obs1 !== e) $display("FAIL lat1_drain[%0d]: got %h want %h", k, obs1, e); else passed++;
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      drv(0, 1, 0, 0, 0, 0, 1, 4'hF, 1); #1;
      e = ev(5, 0, 0, 1, 0, i, 0, 0, 0, 0, 4'h0);
      total++; if (obs0 !== e) $display("FAIL single_out[%0d]: got %h want %h", i, obs0, e); else passed++;
      total++; if (obs1 !== e) $display("FAIL lat1_out[%0d]: got %h want %h", i, obs1, e); else passed++;
      tick();
    end
    e = ev(6, 0, 1, 0, 0, 0, 1, 0, 0, 0, 4'h0);
    total++; if (obs0 !== e) $display("FAIL single_done: got %h want %h", obs0, e); else passed++;
    total++; if (obs1 !== e) $display("FAIL lat1_done: got %h want %h", obs1, e); else passed++;
    tick();
    drv(0, 1, 0, 0, 0, 0, 1, 4'hF, 0); #1;
    e = ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0);
    total++; if (obs0 !== e) $display("FAIL single_end: got %h want %h", obs0, e); else passed++;
    rst1 = 1'b0;
  endtask

  task automatic test_multi_layer;
    logic [22:0] e;
    drv(1, 3, 0, 0, 0, 0, 1, 4'hF, 0); #1;
    tick();
    for (int l = 0; l < 3; l++) begin
      drv(0, 3, 1, 1, 2'(l), 1, 1, 4'hF, 0); #1;
      e = ev(1, l, 0, 0, 0, 0, 0, 0, 0, (l == 0), 4'(1 << l));
      total++; if (obs0 !== e) $display("FAIL multi_load[%0d]: got %h want %h", l, obs0, e); else passed++;
      tick();
      // start held high here must be ignored outside IDLE
      drv(1, 3, 0, 0, 0, 0, 1, 4'hF, 0); #1;
      e = ev(2, l, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0);
      total++; if (obs0 !== e) $display("FAIL multi_mac[%0d]: got %h want %h", l, obs0, e); else passed++;
      tick();
      drv(0, 3, 0, 0, 0, 0, 1, 4'hF, 0);
      for (int k = 0; k < 3; k++) begin
        #1;
        e = ev(3, l, 0, 0, (k == 2), 0, 0, 0, 0, 0, 4'h0);
        total++; if (obs0 !== e) $display("FAIL multi_drain[%0d.%0d]: got %h want %h", l, k, obs0, e); else passed++;
        tick();
      end
      if (l < 2) begin
        for (int i = 0; i < 5; i++) begin
          #1;
          e = (i < 4) ? ev(4, l, 0, 0, 0, i, 0, 0, 1, 1, 4'h0) : ev(4, l, 0, 0, 0, 0, 1, 0, 1, 0, 4'h0);
          total++; if (obs0 !== e) $display("FAIL multi_wb[%0d.%0d]: got %h want %h", l, i, obs0, e); else passed++;
          tick();
        end
      end
    end
    drv(0, 3, 0, 0, 0, 0, 1, 4'hF, 1);
    for (int i = 0; i < 4; i++) begin
      #1;
      e = ev(5, 2, 0, 1, 0, i, 0, 0, 0, 0, 4'h0);
      total++; if (obs0 !== e) $display("FAIL multi_out[%0d]: got %h want %h", i, obs0, e); else passed++;
      tick();
    end
    e = ev(6, 2, 1, 0, 0, 0, 1, 0, 0, 0, 4'h0);
    total++; if (obs0 !== e) $display("FAIL multi_done: got %h want %h", obs0, e); else passed++;
    tick();
    drv(0, 3, 0, 0, 0, 0, 1, 4'hF, 0); #1;
    e = ev(0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0);
    total++; if (obs0 !== e) $display("FAIL multi_idle_hold: got %h want %h", obs0, e); else passed++;
  endtask

  task automatic test_backpressure;
    logic [22:0] e;
    int rp [7] = '{1, 0, 0, 1, 1, 0, 1};
    int sp [7] = '{0, 1, 1, 1, 2, 3, 3};
    drv(1, 0, 0, 0, 0, 0, 1, 4'hF, 0); #1;
    tick();
    drv(0, 0, 0, 0, 0, 1, 1, 4'hF, 0); #1;
    e = ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0);
    total++; if (obs0 !== e) $display("FAIL bp_load: got %h want %h", obs0, e); else passed++;
    tick();
    drv(0, 0, 0, 0, 0, 0, 1, 4'hF, 0);
    repeat (4) tick();
    for (int j = 0; j < 7; j++) begin
      rdy = rp[j][0]; #1;
      e = ev(5, 0, 0, 1, 0, sp[j], 0, 0, 0, 0, 4'h0);
      total++; if (obs0 !== e) $display("FAIL bp_out[%0d]: got %h want %h", j, obs0, e); else passed++;
      tick();
    end
    rdy = 1'b0; #1;
    e = ev(6, 0, 1, 0, 0, 0, 1, 0, 0, 0, 4'h0);
    total++; if (obs0 !== e) $display("FAIL bp_done: got %h want %h", obs0, e); else passed++;
    tick();
  endtask

  task automatic test_reset_mid_job;
    logic [22:0] e;
    drv(1, 3, 0, 0, 0, 0, 1, 4'hF, 0); #1;
    tick();
    for (int l = 0; l < 2; l++) begin
      drv(0, 3, 0, 0, 0, 1, 1, 4'hF, 0);
      tick();
      drv(0, 3, 0, 0, 0, 0, 1, 4'hF, 0);
      repeat (4) tick();
      if (l == 0) repeat (5) tick();
    end
    tick(); tick();
    e = ev(4, 1, 0, 0, 0, 2, 0, 0, 1, 1, 4'h0);
    total++; if (obs0 !== e) $display("FAIL rmid_wb: got %h want %h", obs0, e); else passed++;
    #2 rst = 1'b0;
    #1;
    e = '0;
    total++; if (obs0 !== e) $display("FAIL rmid_async: got %h want %h", obs0, e); else passed++;
    tick();
    total++; if (obs0 !== e) $display("FAIL rmid_hold: got %h want %h", obs0, e); else passed++;
    @(negedge clk); rst = 1'b1;
    tick();
    drv(1, 1, 0, 0, 0, 0, 1, 4'hF, 0); #1;
    tick();
    drv(0, 1, 0, 0, 0, 1, 1, 4'hF, 0);
    tick();
    drv(0, 1, 0, 0, 0, 0, 1, 4'hF, 1);
    repeat (4) tick();
    for (int i = 0; i < 4; i++) begin
      e = ev(5, 0, 0, 1, 0, i, 0, 0, 0, 0, 4'h0);
      total++; if (obs0 !== e) $display("FAIL rmid_out[%0d]: got %h want %h", i, obs0, e); else passed++;
      tick();
    end
    e = ev(6, 0, 1, 0, 0, 0, 1, 0, 0, 0, 4'h0);
    total++; if (obs0 !== e) $display("FAIL rmid_done: got %h want %h", obs0, e); else passed++;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_layer();
    test_multi_layer();
    test_backpressure();
    test_reset_mid_job();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
